// File: rtl/stage2_opra_encode.sv
// stage2_opra_encode: second stage of the OPRA market-data encoder.
// Classifies up to three raw messages per cycle by their category/type bytes,
// compacts the valid ones into a packed block (MSB-first, no gaps) and emits
// per-message control words. Every output is registered (latency 1).
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   original_data_1/2/3              raw messages, priority 1 > 2 > 3
//   message_en_in                    qualifier for all three messages
//   block_data_out                   valid messages packed from slot 0 (top bits)
//   message_en_out                   registered message_en_in
//   message_1/2/3_out                message k if valid, else zero
//   N_type_control_m1/m2/m3_out      classification of message k
//   message_mux_control_m1/m2/m3_out block slot of message k (all ones if invalid)
//   message_number_data_out          number of valid messages
module stage2_opra_encode #(
  parameter int unsigned MAX_ORIGINAL_DATA_BITS    = 264,
  parameter int unsigned MAX_MESSAGE_BITS          = 264,
  parameter int unsigned max_block_bits            = 792,
  parameter int unsigned N_type_control_width      = 2,
  parameter int unsigned message_mux_control_width = 2,
  parameter int unsigned message_number_data_bits  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [MAX_ORIGINAL_DATA_BITS-1:0]    original_data_1,
  input  logic [MAX_ORIGINAL_DATA_BITS-1:0]    original_data_2,
  input  logic [MAX_ORIGINAL_DATA_BITS-1:0]    original_data_3,
  input  logic                                 message_en_in,
  output logic [max_block_bits-1:0]            block_data_out,
  output logic                                 message_en_out,
  output logic [MAX_MESSAGE_BITS-1:0]          message_1_out,
  output logic [MAX_MESSAGE_BITS-1:0]          message_2_out,
  output logic [MAX_MESSAGE_BITS-1:0]          message_3_out,
  output logic [N_type_control_width-1:0]      N_type_control_m1_out,
  output logic [N_type_control_width-1:0]      N_type_control_m2_out,
  output logic [N_type_control_width-1:0]      N_type_control_m3_out,
  output logic [message_mux_control_width-1:0] message_mux_control_m1_out,
  output logic [message_mux_control_width-1:0] message_mux_control_m2_out,
  output logic [message_mux_control_width-1:0] message_mux_control_m3_out,
  output logic [message_number_data_bits-1:0]  message_number_data_out
);

  localparam int unsigned MB  = MAX_MESSAGE_BITS;
  localparam int unsigned Top = MAX_ORIGINAL_DATA_BITS - 1;
  localparam logic [7:0]  CharN = 8'h4E;

  typedef logic [N_type_control_width-1:0]      type_t;
  typedef logic [message_mux_control_width-1:0] mux_t;
  typedef logic [message_number_data_bits-1:0]  cnt_t;

  localparam mux_t MuxInvalid = '1;

  function automatic type_t classify(input logic valid, input logic [7:0] cat,
                                     input logic [7:0] typ);
    if (!valid)          return type_t'(0);
    else if (cat != CharN) return type_t'(3);
    else if (typ == CharN) return type_t'(1);
    else                 return type_t'(2);
  endfunction

  logic [MB-1:0]             raw [3];
  logic [MB-1:0]             msg [3];
  logic [2:0]                valid;
  type_t                     ntype [3];
  mux_t                      slot  [3];
  mux_t                      mux   [3];
  cnt_t                      count;
  logic [max_block_bits-1:0] block;
  logic [MB-1:0]             zero_msg;

  always_comb begin
    zero_msg = {MB{1'b0}};
    raw[0]   = original_data_1;
    raw[1]   = original_data_2;
    raw[2]   = original_data_3;
    for (int k = 0; k < 3; k++) begin
      // A zero participant ID marks an empty message slot.
      valid[k] = message_en_in && (raw[k][Top -: 8] != 8'h00);
      ntype[k] = classify(valid[k], raw[k][Top-8 -: 8], raw[k][Top-16 -: 8]);
      msg[k]   = valid[k] ? raw[k] : zero_msg;
    end
    // Slot of message k = number of valid messages ahead of it.
    slot[0] = mux_t'(0);
    slot[1] = mux_t'(valid[0]);
    slot[2] = mux_t'(valid[0]) + mux_t'(valid[1]);
    for (int k = 0; k < 3; k++) begin
      mux[k] = valid[k] ? slot[k] : MuxInvalid;
    end
    count = cnt_t'(valid[0]) + cnt_t'(valid[1]) + cnt_t'(valid[2]);
    case ({valid[0], valid[1], valid[2]})
      3'b111:  block = {msg[0], msg[1], msg[2]};
      3'b110:  block = {msg[0], msg[1], zero_msg};
      3'b101:  block = {msg[0], msg[2], zero_msg};
      3'b100:  block = {msg[0], zero_msg, zero_msg};
      3'b011:  block = {msg[1], msg[2], zero_msg};
      3'b010:  block = {msg[1], zero_msg, zero_msg};
      3'b001:  block = {msg[2], zero_msg, zero_msg};
      default: block = {zero_msg, zero_msg, zero_msg};
    endcase
  end

  logic [max_block_bits-1:0] block_q;
  logic                      en_q;
  logic [MB-1:0]             msg_q [3];
  type_t                     ntype_q [3];
  mux_t                      mux_q [3];
  cnt_t                      count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q <= '0;
      en_q    <= 1'b0;
      count_q <= '0;
      for (int k = 0; k < 3; k++) begin
        msg_q[k]   <= '0;
        ntype_q[k] <= '0;
        mux_q[k]   <= '0;
      end
    end else begin
      block_q <= block;
      en_q    <= message_en_in;
      count_q <= count;
      for (int k = 0; k < 3; k++) begin
        msg_q[k]   <= msg[k];
        ntype_q[k] <= ntype[k];
        mux_q[k]   <= mux[k];
      end
    end
  end

  assign block_data_out             = block_q;
  assign message_en_out             = en_q;
  assign message_1_out              = msg_q[0];
  assign message_2_out              = msg_q[1];
  assign message_3_out              = msg_q[2];
  assign N_type_control_m1_out      = ntype_q[0];
  assign N_type_control_m2_out      = ntype_q[1];
  assign N_type_control_m3_out      = ntype_q[2];
  assign message_mux_control_m1_out = mux_q[0];
  assign message_mux_control_m2_out = mux_q[1];
  assign message_mux_control_m3_out = mux_q[2];
  assign message_number_data_out    = count_q;

endmodule

// File: tb/tb_stage2_opra_encode.sv
// Self-checking bench for stage2_opra_encode: directed vector table, reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_stage2_opra_encode;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [263:0] d1, d2, d3;
  logic         en;
  logic [791:0] blk;
  logic         en_out;
  logic [263:0] m1, m2, m3;
  logic [1:0]   t1, t2, t3, x1, x2, x3, cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage2_opra_encode dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .original_data_1            (d1),
    .original_data_2            (d2),
    .original_data_3            (d3),
    .message_en_in              (en),
    .block_data_out             (blk),
    .message_en_out             (en_out),
    .message_1_out              (m1),
    .message_2_out              (m2),
    .message_3_out              (m3),
    .N_type_control_m1_out      (t1),
    .N_type_control_m2_out      (t2),
    .N_type_control_m3_out      (t3),
    .message_mux_control_m1_out (x1),
    .message_mux_control_m2_out (x2),
    .message_mux_control_m3_out (x3),
    .message_number_data_out    (cnt)
  );

  typedef struct {
    string        name;
    logic [263:0] d1, d2, d3;
    logic         en;
    logic [1:0]   t1, t2, t3, x1, x2, x3, cnt;
    logic [791:0] blk;
    logic [263:0] m1, m2, m3;
  } vec_t;

  function automatic logic [263:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2, input logic [31:0] seed);
    logic [255:0] pay;
    pay = {8{seed}};
    return {b0, b1, b2, pay[239:0]};
  endfunction

  task automatic chk(input string nm, input logic [791:0] act, input logic [791:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare(input vec_t v);
    chk({v.name, " blk"}, blk, v.blk);
    chk({v.name, " en_out"}, 792'(en_out), 792'(v.en));
    chk({v.name, " m1"}, 792'(m1), 792'(v.m1));
    chk({v.name, " m2"}, 792'(m2), 792'(v.m2));
    chk({v.name, " m3"}, 792'(m3), 792'(v.m3));
    chk({v.name, " t1"}, 792'(t1), 792'(v.t1));
    chk({v.name, " t2"}, 792'(t2), 792'(v.t2));
    chk({v.name, " t3"}, 792'(t3), 792'(v.t3));
    chk({v.name, " x1"}, 792'(x1), 792'(v.x1));
    chk({v.name, " x2"}, 792'(x2), 792'(v.x2));
    chk({v.name, " x3"}, 792'(x3), 792'(v.x3));
    chk({v.name, " cnt"}, 792'(cnt), 792'(v.cnt));
  endtask

  task automatic drive(input vec_t v);
    d1 = v.d1; d2 = v.d2; d3 = v.d3; en = v.en;
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    compare(v);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, " blk"}, blk, '0);
    chk({nm, " msgs"}, 792'({m1, m2, m3}), '0);
    chk({nm, " ctl"}, 792'({en_out, t1, t2, t3, x1, x2, x3, cnt}), '0);
  endtask

  // Reference model: walk messages in priority order, queue the valid ones,
  // then lay the queue out slot by slot.
  function automatic vec_t model(input string nm, input logic [263:0] a,
                                 input logic [263:0] b, input logic [263:0] c,
                                 input logic e);
    vec_t         v;
    logic [263:0] in [3];
    logic [263:0] q [$];
    logic [1:0]   ty [3];
    logic [1:0]   sl [3];
    logic [263:0] mo [3];
    in[0] = a; in[1] = b; in[2] = c;
    for (int k = 0; k < 3; k++) begin
      bit ok;
      ok = e && (in[k][263:256] != 8'h00);
      if (!ok)                         ty[k] = 2'd0;
      else if (in[k][255:248] != 8'h4E) ty[k] = 2'd3;
      else if (in[k][247:240] == 8'h4E) ty[k] = 2'd1;
      else                             ty[k] = 2'd2;
      sl[k] = ok ? 2'(q.size()) : 2'd3;
      mo[k] = ok ? in[k] : '0;
      if (ok) q.push_back(in[k]);
    end
    v.name = nm; v.d1 = a; v.d2 = b; v.d3 = c; v.en = e;
    v.t1 = ty[0]; v.t2 = ty[1]; v.t3 = ty[2];
    v.x1 = sl[0]; v.x2 = sl[1]; v.x3 = sl[2];
    v.m1 = mo[0]; v.m2 = mo[1]; v.m3 = mo[2];
    v.cnt = 2'(q.size());
    v.blk = '0;
    for (int s = 0; s < q.size(); s++) v.blk[791 - 264*s -: 264] = q[s];
    return v;
  endfunction

  function automatic logic [263:0] rnd_msg();
    logic [7:0] b0, b1, b2;
    b0 = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
    b1 = ($urandom_range(1) == 0) ? 8'h4E : 8'($urandom);
    b2 = ($urandom_range(1) == 0) ? 8'h4E : 8'($urandom);
    return mk(b0, b1, b2, $urandom);
  endfunction

  logic [263:0] ma, mb, mc, mz, z;
  vec_t         tbl [7];

  initial begin
    z  = '0;
    ma = mk(8'h41, 8'h4E, 8'h4E, 32'h1111_2222);   // "ANN"
    mb = mk(8'h41, 8'h4E, 8'h53, 32'h3333_4444);   // "ANS"
    mc = mk(8'h41, 8'h58, 8'h59, 32'h5555_6666);   // "AXY"
    mz = mk(8'h00, 8'h4E, 8'h4E, 32'h7777_8888);   // zero participant ID

    tbl[0] = '{"ann_ans", ma, mb, z, 1'b1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2,
               {ma, mb, z}, ma, mb, z};
    tbl[1] = '{"swap", mb, ma, z, 1'b1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2,
               {mb, ma, z}, mb, ma, z};
    tbl[2] = '{"gap", z, ma, mc, 1'b1, 2'd0, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2,
               {ma, mc, z}, z, ma, mc};
    tbl[3] = '{"all3", ma, mb, mc, 1'b1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
               {ma, mb, mc}, ma, mb, mc};
    tbl[4] = '{"en0", ma, mb, mc, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0,
               {z, z, z}, z, z, z};
    tbl[5] = '{"only3", z, z, mc, 1'b1, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1,
               {mc, z, z}, z, z, mc};
    tbl[6] = '{"pid0", mz, mb, mz, 1'b1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd3, 2'd1,
               {mb, z, z}, z, mb, z};

    // Reset held with live inputs: outputs stay zero across clock edges.
    rst_n = 1'b0;
    drive(tbl[3]);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare(tbl[3]);

    for (int i = 0; i < 7; i++) apply(tbl[i]);

    // Mid-stream reset clears outputs without a clock edge.
    apply(tbl[3]);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    apply(tbl[0]);

    // Back-to-back randomized traffic.
    for (int i = 0; i < 300; i++) begin
      vec_t v;
      v = model($sformatf("rnd%0d", i), rnd_msg(), rnd_msg(), rnd_msg(),
                $urandom_range(4) != 0);
      apply(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage2_opra_encode.md
# stage2_opra_encode

Second pipeline stage of the OPRA market-data encoder. Each clock it accepts up to three raw fixed-width OPRA messages and classifies each by its category and type bytes. It compacts the valid messages into a single packed block and emits per-message control words. Downstream stages use these words to select and parse each message. All outputs are registered, with a one-cycle latency.

## Interface
Parameters:
- MAX_ORIGINAL_DATA_BITS, 264: raw message width (33 bytes, byte 0 in bits [263:256]).
- MAX_MESSAGE_BITS, 264: output message width (equals the raw width).
- max_block_bits, 792: packed block width, 3 × MAX_MESSAGE_BITS.
- N_type_control_width, 2: message classification code width.
- message_mux_control_width, 2: block slot index width.
- message_number_data_bits, 2: valid-message count width.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset; one clock, asynchronous, active-low.
- original_data_1/2/3, input, MAX_ORIGINAL_DATA_BITS: raw messages in priority order 1 > 2 > 3.
- message_en_in, input, 1: input qualifier for all three messages.
- block_data_out, output, max_block_bits: valid messages packed MSB-first.
- message_en_out, output, 1: registered message_en_in.
- message_1/2/3_out, output, MAX_MESSAGE_BITS: registered message k if valid, else 0.
- N_type_control_m1/m2/m3_out, output, N_type_control_width: classification of message k.
- message_mux_control_m1/m2/m3_out, output, message_mux_control_width: block slot of message k.
- message_number_data_out, output, message_number_data_bits: number of valid messages (0–3).

## Operation
- Byte fields of message k, MSB-first: byte0 = participant ID, bits [263:256]; byte1 = message category, bits [255:248]; byte2 = message type, bits [247:240]; remaining bytes are payload and are passed through unchanged.
- Message k is valid when message_en_in = 1 and byte0 ≠ 8'h00.
- N_type_control for message k:
  - 2'b00: message invalid.
  - 2'b01: byte1 = 'N' (8'h4E) and byte2 = 'N' (8'h4E).
  - 2'b10: byte1 = 'N' and byte2 ≠ 'N'.
  - 2'b11: any other category.
- Compaction: valid messages are packed in order 1, 2, 3 with no gaps, starting at slot 0.
  - Slot s occupies block_data_out[791−264·s -: 264].
  - Unused slots are zero.
- message_mux_control for message k = the slot index it was placed in (0–2); 2'b11 when the message is invalid.
- message_number_data_out = popcount of the three valid flags.
- message_k_out = original_data_k when message k is valid, else all zeros.
- message_en_in = 0: every valid flag is 0, so the registered result is all-zero messages, block, types and count, with every mux control = 2'b11. message_en_out = 0.
- No internal state beyond the single output register stage; there are no back-pressure or handshake inputs.

## Timing
- All outputs update on the rising edge of clk, one cycle after their inputs are sampled (latency 1, throughput 1 set per cycle).
- Reset (rst_n low, asynchronous) forces every output to 0 immediately, including every mux control and message_en_out.
- After rst_n rises, outputs reflect inputs from the first rising edge onward.
- Reset asserted mid-stream discards any in-flight result; no partial output appears.
- Inputs change only between edges; the stage has no combinational input-to-output path.

## Test plan
- Reset: hold rst_n = 0 with inputs set -> all outputs 0, mux controls 2'b00, count 0; after release the first edge loads the valid result.
- Input d1 = "ANN…" (bytes 41 4E 4E, then payload), d2 = "ANS…" (41 4E 53, then payload), d3 = 0, en = 1 -> next edge:
  - types 01/10/00.
  - mux controls 0/1/3.
  - count 2.
  - block = {d1, d2, 264'b0}.
  - m3_out = 0; m1_out = d1, m2_out = d2.
- Swap d1 and d2 from the previous case -> types 10/01/00; block = {d1_new, d2_new, 0}; count 2.
- Gap compaction: d1 = 0, d2 = "ANN…", d3 = "AXY…" -> mux controls 3/0/1; types 00/01/11; block = {d2, d3, 0}; count 1+1 = 2.
- All three messages valid -> count 3, mux controls 0/1/2, block = {d1, d2, d3}.
- en = 0 with nonzero data -> next edge: outputs zero, mux controls 3/3/3, count 0, message_en_out = 0; assert rst_n low mid-stream -> outputs cleared without waiting for a clock edge.
